disp_axis_packer: RTL and testbench
===================================

// Module: disp_axis_packer
// PURPOSE
//  Consumes the 9-bit WTA disparity stream ({SOF, disparity[7:0]}, qualified by en & pixelEN) and
//  repackages it as an AXI4-Stream video stream (tuser = SOF, tlast = end of line) toward the VDMA/
//  post-filter. The WTA pipeline cannot be stalled, so an internal FIFO absorbs downstream backpressure;
//  words arriving into a full FIFO are dropped and flagged. Tracks column/row to generate tlast/frame_done.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>=2)
//  IMG_HEIGHT  480  lines per frame (>=1)
//  DISP_WIDTH  8    disparity bits (SOF is bit DISP_WIDTH of disparity_in)
//  FIFO_DEPTH  16   FIFO entries, power of 2, >=4
// PORTS
//  clk            in   1             system clock
//  rst            in   1             synchronous reset, active-high
//  en             in   1             global enable (same as WTA en)
//  pixelEN        in   1             pixel strobe; word accepted when en & pixelEN
//  disparity_in   in   DISP_WIDTH+1  {SOF, disparity}
//  m_axis_tdata   out  DISP_WIDTH    disparity of FIFO head
//  m_axis_tvalid  out  1             FIFO non-empty
//  m_axis_tready  in   1             downstream ready
//  m_axis_tuser   out  1             SOF of FIFO head
//  m_axis_tlast   out  1             EOL of FIFO head
//  fifo_count     out  log2(DEPTH)+1 current occupancy
//  overflow       out  1             sticky: >=1 word dropped
//  sof_err        out  1             sticky: SOF seen with col != 0
//  frame_done     out  1             1-cycle pulse: last pixel of frame accepted
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; col=row=0; state WAIT_SOF. Reset mid-frame discards FIFO contents.
//  - acc = en & pixelEN. Nothing changes when acc=0 except FIFO pops.
//  - FSM WAIT_SOF: acc with SOF=0 -> word discarded (not counted, not flagged); acc with SOF=1 -> word
//    processed as col=0,row=0, go STREAM.
//  - STREAM: each acc word gets tag eol = (col==IMG_WIDTH-1), tuser = SOF. After: if eol {col=0;
//    row = (row==IMG_HEIGHT-1) ? 0 : row+1} else col++. frame_done pulses next cycle when eol &
//    row==IMG_HEIGHT-1. Row wrap stays in STREAM (next frame's SOF expected at col=0,row=0).
//  - SOF=1 in STREAM with col!=0 or row!=0: sof_err<=1, word treated as col=0,row=0 (resync). SOF at
//    col=0,row=0 is normal.
//  - FIFO entry = {eol, SOF, disparity}, FWFT: head visible on m_axis_* while tvalid=1.
//  - pop = tvalid & tready. push = acc & word processed & (count<FIFO_DEPTH | pop). Push and pop in
//    the same cycle on a full FIFO both occur (count unchanged).
//  - Drop = processed word with count==FIFO_DEPTH and no pop: overflow<=1; col/row still advance
//    (geometry preserved; a dropped eol/SOF is lost downstream).
//  - Latency: word accepted at edge N is on m_axis at N+1 if FIFO was empty.
//  - tdata/tuser/tlast held stable while tvalid & ~tready (AXI rule). Sticky flags clear only on rst.
// TESTING
//  1 Reset, tready=1, 3 words SOF=0 then SOF word d=5 -> first 3 dropped silently; tvalid one cycle
//    after SOF word, tdata=5, tuser=1, overflow=0.
//  2 IMG_WIDTH=4,IMG_HEIGHT=2, 8 contiguous words d=0..7 -> tlast on d=3 and d=7 only, frame_done
//    pulse once after d=7, tuser only on d=0.
//  3 tready=0, FIFO_DEPTH=16, 20 words -> fifo_count=16, overflow=1, words 17..20 absent; then
//    tready=1 -> exactly 16 words out in order.
//  4 FIFO full, tready=1 and acc same cycle -> push and pop both occur, count stays 16, overflow stays 0.
//  5 SOF injected at col=2 -> sof_err=1, that word tuser=1, tlast occurs IMG_WIDTH-1 words later.
//  6 rst asserted mid-line with 5 words queued -> next cycle tvalid=0, count=0, flags 0, WAIT_SOF.

Source files
------------

// File: rtl/disp_axis_packer.sv
// Repackages the non-stallable WTA disparity stream into AXI4-Stream video (tuser=SOF, tlast=EOL).
// A FWFT FIFO absorbs downstream backpressure; words that arrive while it is full are dropped and flagged.
module disp_axis_packer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DISP_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          pixelEN,
    input  logic [DISP_WIDTH:0]           disparity_in,
    output logic [DISP_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          sof_err,
    output logic                          frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] STREAM   = 1'b1;

    typedef struct packed {
        logic                  eol;
        logic                  sof;
        logic [DISP_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [0:0]      state;
    logic [CW-1:0]   col, eff_col;
    logic [RW-1:0]   row, eff_row;
    logic            acc, sof, processed, eol, push, pop, full;
    entry_t          head;

    assign acc       = en & pixelEN;
    assign sof       = disparity_in[DISP_WIDTH];
    assign processed = acc & ((state == STREAM) | sof);
    // An SOF always restarts geometry, whether it is on time or a resync.
    assign eff_col   = sof ? '0 : col;
    assign eff_row   = sof ? '0 : row;
    assign eol       = (eff_col == COL_LAST);
    assign full      = (fifo_count == CNT_FULL);
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign push      = processed & (~full | pop);

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    assign m_axis_tuser  = m_axis_tvalid & head.sof;
    assign m_axis_tlast  = m_axis_tvalid & head.eol;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{eol: eol, sof: sof, data: disparity_in[DISP_WIDTH-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_SOF;
            col        <= '0;
            row        <= '0;
            overflow   <= 1'b0;
            sof_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= processed & eol & (eff_row == ROW_LAST);
            if (processed) begin
                state <= STREAM;
                if (sof && (state == STREAM) && (col != '0 || row != '0)) sof_err <= 1'b1;
                // Dropped words still advance geometry so later lines stay aligned.
                if (full && !pop) overflow <= 1'b1;
                if (eol) begin
                    col <= '0;
                    row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end
        end
    end
endmodule

// File: tb/tb_disp_axis_packer.sv
// Bench for disp_axis_packer: directed vector table, corner-case sequences and random traffic
// checked against a pixel-index/queue reference model.
module tb_disp_axis_packer;
    localparam int W = 4, H = 2, DW = 8, D = 16;

    logic clk = 1'b0, rst, en, pixelEN, m_axis_tready;
    logic [DW:0] disparity_in;
    logic [DW-1:0] m_axis_tdata;
    logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, sof_err, frame_done;
    logic [4:0] fifo_count;

    disp_axis_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DISP_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .pixelEN(pixelEN), .disparity_in(disparity_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .fifo_count(fifo_count),
        .overflow(overflow), .sof_err(sof_err), .frame_done(frame_done));

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic sof; logic eol; } word_t;
    word_t q[$];
    logic [9:0] popped[$];
    int  pos, checks = 0, failures = 0, fd_cnt = 0;
    bit  in_frame, m_ovf, m_serr, m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic p, input logic [8:0] din, input logic rdy);
        bit pop, s, proc;
        word_t w;
        if (r) begin
            q.delete(); in_frame = 0; pos = 0; m_ovf = 0; m_serr = 0; m_fd = 0;
            return;
        end
        pop  = (q.size() > 0) && rdy;
        s    = din[8];
        proc = e && p && (in_frame || s);
        m_fd = 0;
        if (pop) void'(q.pop_front());
        if (proc) begin
            if (s) begin
                if (in_frame && pos != 0) m_serr = 1;
                pos = 0;
            end
            in_frame = 1;
            w.d = din[7:0]; w.sof = s; w.eol = (pos % W == W - 1);
            if (pos == W * H - 1) m_fd = 1;
            if (q.size() < D) q.push_back(w);
            else m_ovf = 1;
            pos = (pos + 1) % (W * H);
        end
    endtask

    task automatic compare();
        chk("tvalid", m_axis_tvalid, q.size() > 0);
        chk("fifo_count", fifo_count, q.size());
        if (q.size() > 0) begin
            chk("tdata", m_axis_tdata, q[0].d);
            chk("tuser", m_axis_tuser, q[0].sof);
            chk("tlast", m_axis_tlast, q[0].eol);
        end
        chk("overflow", overflow, m_ovf);
        chk("sof_err", sof_err, m_serr);
        chk("frame_done", frame_done, m_fd);
        if (frame_done) fd_cnt++;
    endtask

    // Called at a falling edge: drive, record any handshake, clock, update model, check.
    task automatic step(input logic r, input logic e, input logic p, input logic [8:0] din, input logic rdy);
        rst = r; en = e; pixelEN = p; disparity_in = din; m_axis_tready = rdy;
        if (!r && m_axis_tvalid && rdy) popped.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
        @(posedge clk);
        model(r, e, p, din, rdy);
        @(negedge clk);
        compare();
    endtask

    typedef struct {
        logic r, e, p; logic [8:0] din; logic rdy;
        logic xv; logic [7:0] xd; logic xu; logic [4:0] xc; logic xo;
    } vec_t;
    vec_t tbl[6];

    initial begin
        rst = 1; en = 0; pixelEN = 0; disparity_in = '0; m_axis_tready = 0;
        tbl[0] = '{1, 0, 0, 9'h000, 1, 0, 8'd0, 0, 5'd0, 0};
        tbl[1] = '{0, 1, 1, 9'h011, 1, 0, 8'd0, 0, 5'd0, 0};
        tbl[2] = '{0, 1, 1, 9'h022, 1, 0, 8'd0, 0, 5'd0, 0};
        tbl[3] = '{0, 1, 1, 9'h033, 1, 0, 8'd0, 0, 5'd0, 0};
        tbl[4] = '{0, 1, 1, 9'h105, 1, 1, 8'd5, 1, 5'd1, 0};
        tbl[5] = '{0, 0, 0, 9'h000, 1, 0, 8'd0, 0, 5'd0, 0};
        @(negedge clk);

        // 1: words before SOF are silently discarded; SOF word visible one cycle later
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].p, tbl[i].din, tbl[i].rdy);
            chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, tbl[i].xv);
            chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].xc);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].xo);
            if (tbl[i].xv) begin
                chk($sformatf("vec%0d_tdata", i), m_axis_tdata, tbl[i].xd);
                chk($sformatf("vec%0d_tuser", i), m_axis_tuser, tbl[i].xu);
            end
        end

        // 2: one full 4x2 frame, tlast on d=3/7, single frame_done, tuser on d=0
        step(1, 0, 0, 0, 1);
        popped.delete(); fd_cnt = 0;
        for (int i = 0; i < 8; i++) step(0, 1, 1, {(i == 0), 8'(i)}, 1);
        step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
        chk("frame_pop_count", popped.size(), 8);
        chk("frame_done_pulses", fd_cnt, 1);
        foreach (popped[i]) begin
            chk($sformatf("frame_tlast%0d", i), popped[i][9], (i == 3 || i == 7));
            chk($sformatf("frame_tuser%0d", i), popped[i][8], (i == 0));
        end

        // 3: 20 words into a stalled 16-entry FIFO, then drain
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, {(i == 0), 8'(i)}, 0);
        chk("ovf_count_full", fifo_count, 16);
        chk("ovf_flag", overflow, 1);
        popped.delete();
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1);
        chk("drain_size", popped.size(), 16);
        foreach (popped[i]) chk($sformatf("drain_order%0d", i), popped[i][7:0], i);

        // 4: full FIFO with simultaneous push and pop
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, {(i == 0), 8'(i)}, 0);
        step(0, 1, 1, {1'b0, 8'd16}, 1);
        chk("pushpop_count", fifo_count, 16);
        chk("pushpop_no_ovf", overflow, 0);

        // 5: SOF at col=2 resyncs the line
        step(1, 0, 0, 0, 1);
        popped.delete();
        step(0, 1, 1, 9'h100, 1); step(0, 1, 1, 9'h001, 1); step(0, 1, 1, 9'h102, 1);
        chk("resync_sof_err", sof_err, 1);
        for (int i = 3; i < 6; i++) step(0, 1, 1, {1'b0, 8'(i)}, 1);
        step(0, 0, 0, 0, 1);
        chk("resync_pops", popped.size(), 6);
        if (popped.size() == 6) begin
            chk("resync_tuser", popped[2][9:8], 2'b01);
            chk("resync_mid", popped[4][9], 0);
            chk("resync_tlast", popped[5][9], 1);
        end

        // 6: reset mid-line with 5 queued words, then FSM back in WAIT_SOF
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, {(i == 0), 8'(i)}, 0);
        chk("pre_rst_count", fifo_count, 5);
        step(1, 0, 0, 0, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_flags", {overflow, sof_err, frame_done}, 0);
        step(0, 1, 1, 9'h009, 1);
        chk("rst_wait_sof", fifo_count, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                 {($urandom_range(0, 15) == 0), 8'($urandom)}, ($urandom_range(0, 2) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
